// File: rtl/iob_soc_versat_rst_seq_pkg.sv
// Shared definitions for the FPGA reset sequencer: state encoding and default timing.
package iob_soc_versat_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_HOLD       = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAIL       = 3'd5
    } rst_state_t;

    localparam int DEF_STARTUP_DELAY   = 5;
    localparam int DEF_RST_DURATION    = 10;
    localparam int DEF_CALIB_TIMEOUT   = 2000000;
    localparam int DEF_DEBOUNCE_CYCLES = 65536;
    localparam int DEF_USE_CALIB       = 1;
    localparam int DEF_CNT_W           = 22;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/iob_soc_versat_debounce.sv
// Button conditioner: synchronise, require DEBOUNCE_CYCLES stable cycles, pulse on accepted press.
module iob_soc_versat_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cke_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            btn_s;
    logic            level_q;
    logic            press_q;
    logic [DB_W-1:0] db_cnt_q;

    iob_sync #(.DATA_W(1)) u_btn_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .signal_i(btn_i),
        .signal_o(btn_s)
    );

    // The pulse is held while cke_i is low so the sequencer still consumes it exactly once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            db_cnt_q <= '0;
        end else if (cke_i) begin
            press_q <= 1'b0;
            if (btn_s == level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_q <= '0;
                level_q  <= btn_s;
                press_q  <= btn_s;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/iob_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
module iob_sync #(
    parameter int DATA_W = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] signal_i,
    output logic [DATA_W-1:0] signal_o
);

    logic [DATA_W-1:0] meta_q;
    logic [DATA_W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= signal_i;
            sync_q <= meta_q;
        end
    end

    assign signal_o = sync_q;

endmodule

// File: rtl/iob_soc_versat_fpga_rst_seq.sv
// Board-level startup sequencer: waits for clock lock and DDR calibration, then releases the SoC reset.
module iob_soc_versat_fpga_rst_seq
    import iob_soc_versat_rst_seq_pkg::*;
#(
    parameter int STARTUP_DELAY   = DEF_STARTUP_DELAY,
    parameter int RST_DURATION    = DEF_RST_DURATION,
    parameter int CALIB_TIMEOUT   = DEF_CALIB_TIMEOUT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int USE_CALIB       = DEF_USE_CALIB,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cke_i,
    input  logic       btn_rst_i,
    input  logic       mmcm_locked_i,
    input  logic       calib_done_i,
    output logic       soc_arst_o,
    output logic       ddr_ok_o,
    output logic       calib_timeout_o,
    output logic [2:0] state_o,
    output logic [7:0] rst_count_o
);

    rst_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             restart;
    logic             locked_s, calib_s, press;
    logic             arst_q, ddr_ok_q;
    logic             timeout_q, timeout_d;
    logic [7:0]       rst_count_q, rst_count_d;

    iob_sync #(.DATA_W(2)) u_status_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .signal_i({mmcm_locked_i, calib_done_i}),
        .signal_o({locked_s, calib_s})
    );

    iob_soc_versat_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cke_i  (cke_i),
        .btn_i  (btn_rst_i),
        .press_o(press)
    );

    // A press outranks every other event and always restarts the INIT delay.
    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        rst_count_d = rst_count_q;
        restart     = 1'b0;
        if (press) begin
            state_d     = ST_INIT;
            restart     = 1'b1;
            rst_count_d = sat_inc8(rst_count_q);
            if (state_q == ST_FAIL) timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == CNT_W'(STARTUP_DELAY - 1)) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) state_d = (USE_CALIB != 0) ? ST_WAIT_CALIB : ST_HOLD;
                end
                ST_WAIT_CALIB: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (calib_s) begin
                        state_d = ST_HOLD;
                    end else if (cnt_q == CNT_W'(CALIB_TIMEOUT - 1)) begin
                        state_d   = ST_FAIL;
                        timeout_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!locked_s) state_d = ST_WAIT_LOCK;
                    else if ((USE_CALIB != 0) && !calib_s) state_d = ST_WAIT_CALIB;
                    else if (cnt_q == CNT_W'(RST_DURATION - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s) state_d = ST_WAIT_LOCK;
                    else if ((USE_CALIB != 0) && !calib_s) state_d = ST_WAIT_CALIB;
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            arst_q      <= 1'b1;
            timeout_q   <= 1'b0;
            rst_count_q <= '0;
        end else if (cke_i) begin
            state_q     <= state_d;
            cnt_q       <= (restart || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
            arst_q      <= (state_d != ST_RUN);
            timeout_q   <= timeout_d;
            rst_count_q <= rst_count_d;
        end
    end

    // Calibration status keeps tracking while the sequencer is frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i) ddr_ok_q <= 1'b0;
        else       ddr_ok_q <= calib_s;
    end

    assign soc_arst_o      = arst_q;
    assign ddr_ok_o        = ddr_ok_q;
    assign calib_timeout_o = timeout_q;
    assign state_o         = state_q;
    assign rst_count_o     = rst_count_q;

endmodule
